// File: rtl/i2s_dac_serializer.sv
// rtl/i2s_dac_serializer.sv - double-buffered I2S / left-justified DAC serializer (option: LEFT_JUSTIFIED_EN)
module i2s_dac_serializer #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 2
) (
  input  logic              OSC_CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] lsound_in,
  input  logic [DATA_W-1:0] rsound_in,
  input  logic              sample_valid,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              frame_load,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic              dacdat_q, dacdat_d;
  logic              frame_load_q, frame_load_d;
  logic              underrun_q, underrun_d;
  logic [7:0]        underrun_cnt_q, underrun_cnt_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic              fresh_q, fresh_d;

  logic              wrap, fall, last_bit, load;
  logic              slot_r, dat_bit;
  logic [DATA_W-1:0] word;
  int                bit_idx, b;

  // Next-state logic: BCLK divider, bit/slot counter, double buffer, serial data bit
  always_comb begin
    wrap     = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    fall     = wrap && bclk_q;
    last_bit = (bit_cnt_q == BIT_W'(FRAME_W - 1));
    load     = fall && last_bit;

    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    if (fall) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
    end

    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    frame_l_d      = frame_l_q;
    frame_r_d      = frame_r_q;
    fresh_d        = fresh_q;
    frame_load_d   = 1'b0;
    underrun_d     = 1'b0;
    if (load) begin
      frame_load_d = 1'b1;
      fresh_d      = 1'b0;
      if (sample_valid) begin
        // A strobe landing on the load cycle goes straight into the frame;
        // it also becomes the value repeated by any later underrun.
        frame_l_d = lsound_in;
        frame_r_d = rsound_in;
        hold_l_d  = lsound_in;
        hold_r_d  = rsound_in;
      end else begin
        frame_l_d  = hold_l_q;
        frame_r_d  = hold_r_q;
        underrun_d = ~fresh_q;
      end
    end else if (sample_valid) begin
      hold_l_d = lsound_in;
      hold_r_d = rsound_in;
      fresh_d  = 1'b1;
    end

    underrun_cnt_d = underrun_cnt_q;
    if (underrun_d && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end

    // Data bit is selected from the counter and frame values that take effect
    // on this fall, so the bit for a freshly loaded frame is already correct.
    bit_idx = int'(bit_cnt_d);
    slot_r  = (bit_idx >= SLOT_W);
    b       = slot_r ? (bit_idx - SLOT_W) : bit_idx;
    word    = slot_r ? frame_r_d : frame_l_d;
    dat_bit = 1'b0;
`ifdef LEFT_JUSTIFIED_EN
    if (b < DATA_W) begin
      dat_bit = |(word & (DATA_W'(1) << (DATA_W - 1 - b)));
    end
`else
    if ((b >= 1) && (b <= DATA_W)) begin
      dat_bit = |(word & (DATA_W'(1) << (DATA_W - b)));
    end
`endif
    lrck_d   = fall ? slot_r : lrck_q;
    dacdat_d = fall ? dat_bit : dacdat_q;
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge OSC_CLK) begin
    if (reset) begin
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      bclk_q         <= 1'b0;
      lrck_q         <= 1'b0;
      dacdat_q       <= 1'b0;
      frame_load_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'd0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      frame_l_q      <= '0;
      frame_r_q      <= '0;
      fresh_q        <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      bclk_q         <= bclk_d;
      lrck_q         <= lrck_d;
      dacdat_q       <= dacdat_d;
      frame_load_q   <= frame_load_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      frame_l_q      <= frame_l_d;
      frame_r_q      <= frame_r_d;
      fresh_q        <= fresh_d;
    end
  end

  assign AUD_BCLK     = bclk_q;
  assign AUD_DACLRCK  = lrck_q;
  assign AUD_DACDAT   = dacdat_q;
  assign frame_load   = frame_load_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb/tb_i2s_dac_serializer.sv - self-checking bench for i2s_dac_serializer
module tb_i2s_dac_serializer;

  localparam int D = 2;
  localparam int P = 2 * D;
  localparam int FR = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] lsound_in = '0;
  logic [23:0] rsound_in = '0;
  logic        sample_valid = 1'b0;
  logic        AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_load, underrun;
  logic [7:0]  underrun_cnt;

  i2s_dac_serializer #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(D)) dut (
    .OSC_CLK(clk), .reset(reset), .lsound_in(lsound_in), .rsound_in(rsound_in),
    .sample_valid(sample_valid), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT), .frame_load(frame_load), .underrun(underrun),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: k = OSC_CLK edges since reset release
  int          k = 0;
  int          cur_n = 0;
  bit          last_fall = 0;
  logic [23:0] m_hl, m_hr, m_fl, m_fr;
  bit          m_fresh;
  int          m_cnt, m_raw;
  bit          e_bclk, e_lrck, e_dat, e_fl, e_ur;
  logic [23:0] cap_l, cap_r;

  typedef struct {
    int          mode;   // 0 none, 1 strobe mid-frame, 2 strobe on load cycle, 3 two strobes
    logic [23:0] l1, r1, l2, r2;
    logic [23:0] el, er;
    bit          eur;
    bit          chkw;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h want %0h", name, k, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("bclk", int'(AUD_BCLK), int'(e_bclk));
    chk("lrck", int'(AUD_DACLRCK), int'(e_lrck));
    chk("dacdat", int'(AUD_DACDAT), int'(e_dat));
    chk("frame_load", int'(frame_load), int'(e_fl));
    chk("underrun", int'(underrun), int'(e_ur));
    chk("underrun_cnt", int'(underrun_cnt), m_cnt);
  endtask

  task automatic model_reset();
    k = 0; cur_n = 0; last_fall = 0;
    m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0; m_fresh = 0; m_cnt = 0;
    e_bclk = 0; e_lrck = 0; e_dat = 0; e_fl = 0; e_ur = 0;
  endtask

  task automatic model_step(input bit sv, input logic [23:0] li, input logic [23:0] ri);
    int b;
    logic [23:0] w;
    k++;
    e_fl = 0; e_ur = 0;
    e_bclk = ((k / D) % 2) == 1;
    last_fall = (k % P) == 0;
    if (last_fall) cur_n = (k / P) % FR;
    if (last_fall && cur_n == 0) begin
      e_fl = 1;
      if (sv) begin
        m_fl = li; m_fr = ri; m_hl = li; m_hr = ri;
      end else begin
        m_fl = m_hl; m_fr = m_hr;
        if (!m_fresh) begin
          e_ur = 1; m_raw++;
          if (m_cnt < 255) m_cnt++;
        end
      end
      m_fresh = 0;
    end else if (sv) begin
      m_hl = li; m_hr = ri; m_fresh = 1;
    end
    if (last_fall) begin
      e_lrck = cur_n >= 32;
      b = cur_n % 32;
      w = (cur_n >= 32) ? m_fr : m_fl;
`ifdef LEFT_JUSTIFIED_EN
      e_dat = (b < 24) ? (((w >> (23 - b)) & 24'd1) != 0) : 1'b0;
`else
      e_dat = (b >= 1 && b <= 24) ? (((w >> (24 - b)) & 24'd1) != 0) : 1'b0;
`endif
    end
  endtask

  task automatic capture();
    int b;
    if (!last_fall) return;
    if (cur_n == 0) begin cap_l = '0; cap_r = '0; end
    b = cur_n % 32;
`ifdef LEFT_JUSTIFIED_EN
    if (b < 24) begin
      if (cur_n < 32) cap_l = cap_l | (24'(AUD_DACDAT) << (23 - b));
      else            cap_r = cap_r | (24'(AUD_DACDAT) << (23 - b));
    end
`else
    if (b >= 1 && b <= 24) begin
      if (cur_n < 32) cap_l = cap_l | (24'(AUD_DACDAT) << (24 - b));
      else            cap_r = cap_r | (24'(AUD_DACDAT) << (24 - b));
    end
`endif
  endtask

  task automatic tick();
    bit sv;
    logic [23:0] li, ri;
    sv = sample_valid; li = lsound_in; ri = rsound_in;
    @(posedge clk); #1;
    model_step(sv, li, ri);
    compare_all();
    capture();
  endtask

  task automatic reset_tick();
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    compare_all();
  endtask

  task automatic strobe(input logic [23:0] l, input logic [23:0] r);
    sample_valid = 1'b1; lsound_in = l; rsound_in = r;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic run_to_load_minus1();
    while (((k + 1) % (P * FR)) != 0) tick();
  endtask

  initial begin
    bit got_fl, got_ur;
    int guard;
    vecs[0] = '{0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h000000, 24'h000000, 1, 1};
    vecs[1] = '{1, 24'h0, 24'h0, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 0, 1};
    vecs[2] = '{0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h800001, 24'h7FFFFE, 1, 1};
    vecs[3] = '{0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h800001, 24'h7FFFFE, 1, 1};
    vecs[4] = '{0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h800001, 24'h7FFFFE, 1, 1};
    vecs[5] = '{2, 24'h0, 24'h0, 24'h123456, 24'h0ABCDE, 24'h123456, 24'h0ABCDE, 0, 1};
    vecs[6] = '{0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1, 0};
    vecs[7] = '{3, 24'h000AAA, 24'h000AAA, 24'h000555, 24'h000555, 24'h000555, 24'h000555, 0, 1};
    m_raw = 0; cap_l = '0; cap_r = '0;

    repeat (3) reset_tick();
    reset = 1'b0;
    tick(); chk("bclk_pre_rise", int'(AUD_BCLK), 0);
    tick(); chk("bclk_first_rise", int'(AUD_BCLK), 1);

    // table of frame scenarios
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].mode == 1) strobe(vecs[i].l2, vecs[i].r2);
      if (vecs[i].mode == 3) begin
        strobe(vecs[i].l1, vecs[i].r1);
        repeat (7) tick();
        strobe(vecs[i].l2, vecs[i].r2);
      end
      run_to_load_minus1();
      if (vecs[i].mode == 2) strobe(vecs[i].l2, vecs[i].r2);
      else tick();
      got_fl = frame_load; got_ur = underrun;
      chk($sformatf("vec%0d_frame_load", i), int'(got_fl), 1);
      chk($sformatf("vec%0d_underrun", i), int'(got_ur), int'(vecs[i].eur));
      repeat (P * 60) tick();
      if (vecs[i].chkw) begin
        chk($sformatf("vec%0d_left_word", i), int'(cap_l), int'(vecs[i].el));
        chk($sformatf("vec%0d_right_word", i), int'(cap_r), int'(vecs[i].er));
      end
    end
    chk("underrun_cnt_after_table", int'(underrun_cnt), 5);

    // randomized traffic against the model
    for (int i = 0; i < 2048; i++) begin
      sample_valid = ($urandom_range(0, 99) < 3);
      lsound_in = 24'($urandom);
      rsound_in = 24'($urandom);
      tick();
    end
    sample_valid = 1'b0;

    // reset in the middle of the right slot
    guard = 0;
    tick();
    while (!(last_fall && cur_n == 40) && guard < 1000) begin tick(); guard++; end
    chk("reach_bit40", int'(last_fall && cur_n == 40), 1);
    reset_tick();
    chk("rst_bclk", int'(AUD_BCLK), 0);
    chk("rst_lrck", int'(AUD_DACLRCK), 0);
    chk("rst_dacdat", int'(AUD_DACDAT), 0);
    chk("rst_cnt", int'(underrun_cnt), 0);
    reset = 1'b0;
    tick(); chk("bclk_pre_rise2", int'(AUD_BCLK), 0);
    tick(); chk("bclk_first_rise2", int'(AUD_BCLK), 1);
    run_to_load_minus1();
    tick();
    chk("first_load_underrun2", int'(underrun), 1);

    // saturation: keep starving the link until more than 255 underruns
    m_raw = 1;
    guard = 0;
    while (m_raw < 257 && guard < 70000) begin tick(); guard++; end
    chk("sat_reached", int'(m_raw >= 257), 1);
    chk("underrun_cnt_sat", int'(underrun_cnt), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
